// File: rtl/dmem_port_sched.sv
// ---------------------------------------------------------------------------
// dmem_port_sched
//   Puts the two memory-stage lanes of the dual-issue pipeline onto one
//   single-ported data memory. Lane 1 is always older than lane 2, so it is
//   issued first. Same-address hazards within a pair are resolved when the
//   pair is captured:
//     - lane 1 store and lane 2 load : lane 2 gets the store data forwarded
//     - two stores                   : only the younger store is issued
//     - two loads                    : one access fills both results
//   The pipeline is stalled until the pair is finished. o_Done then pulses
//   for one cycle with o_RD1/o_RD2 valid.
//
// Ports
//   clk, rst_n                   clock; asynchronous reset, active HIGH
//   i_MemRead*/i_MemWrite*       per-lane load/store request
//   i_Addr*/i_WData*             per-lane address / store data
//   o_Stall, o_Done              pipeline freeze / pair-complete pulse
//   o_RD1, o_RD2                 load results, held between pairs
//   o_MemReq/WE/Addr/WData       memory request side
//   i_MemGnt, i_MemRData         grant; read data one cycle after the grant
// ---------------------------------------------------------------------------
module dmem_port_sched #(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_MemRead1,
   input  logic               i_MemWrite1,
   input  logic [D_WIDTH-1:0] i_Addr1,
   input  logic [D_WIDTH-1:0] i_WData1,
   input  logic               i_MemRead2,
   input  logic               i_MemWrite2,
   input  logic [D_WIDTH-1:0] i_Addr2,
   input  logic [D_WIDTH-1:0] i_WData2,
   output logic               o_Stall,
   output logic               o_Done,
   output logic [D_WIDTH-1:0] o_RD1,
   output logic [D_WIDTH-1:0] o_RD2,
   output logic               o_MemReq,
   output logic               o_MemWE,
   output logic [D_WIDTH-1:0] o_MemAddr,
   output logic [D_WIDTH-1:0] o_MemWData,
   input  logic               i_MemGnt,
   input  logic [D_WIDTH-1:0] i_MemRData
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY   = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               pend1_q, pend1_d, pend2_q, pend2_d;
   logic               we1_q, we1_d, we2_q, we2_d;
   logic               shared_q, shared_d;
   logic [1:0]         tag_q, tag_d;       // bit0 -> o_RD1, bit1 -> o_RD2
   logic [D_WIDTH-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
   logic [D_WIDTH-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
   logic [D_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

   // Request decode; a lane with both read and write set is treated as a store.
   logic req1, req2, ld1, ld2, same_addr;
   logic hz_fwd, hz_ww, hz_rr;

   assign req1      = i_MemRead1 | i_MemWrite1;
   assign req2      = i_MemRead2 | i_MemWrite2;
   assign ld1       = i_MemRead1 & ~i_MemWrite1;
   assign ld2       = i_MemRead2 & ~i_MemWrite2;
   assign same_addr = (i_Addr1 == i_Addr2);
   assign hz_fwd    = i_MemWrite1 & ld2 & same_addr;
   assign hz_ww     = i_MemWrite1 & i_MemWrite2 & same_addr;
   assign hz_rr     = ld1 & ld2 & same_addr;

   // Issue the oldest pending lane: lane 2 only once lane 1 is finished.
   logic               sel2;
   logic               cur_we;
   logic [D_WIDTH-1:0] cur_addr, cur_wdata;

   assign sel2      = ~pend1_q;
   assign cur_we    = sel2 ? we2_q    : we1_q;
   assign cur_addr  = sel2 ? addr2_q  : addr1_q;
   assign cur_wdata = sel2 ? wdata2_q : wdata1_q;

   always_comb begin
      state_d  = state_q;
      pend1_d  = pend1_q;
      pend2_d  = pend2_q;
      we1_d    = we1_q;
      we2_d    = we2_q;
      shared_d = shared_q;
      tag_d    = tag_q;
      addr1_d  = addr1_q;
      addr2_d  = addr2_q;
      wdata1_d = wdata1_q;
      wdata2_d = wdata2_q;
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;

      case (state_q)
         S_IDLE: begin
            if (req1 | req2) begin
               addr1_d  = i_Addr1;
               addr2_d  = i_Addr2;
               wdata1_d = i_WData1;
               wdata2_d = i_WData2;
               we1_d    = i_MemWrite1;
               we2_d    = i_MemWrite2;
               pend1_d  = req1 & ~hz_ww;
               pend2_d  = req2 & ~hz_fwd & ~hz_rr;
               shared_d = hz_rr;
               if (hz_fwd) rd2_d = i_WData1;
               state_d  = S_BUSY;
            end
         end

         S_BUSY: begin
            if (pend1_q | pend2_q) begin
               if (i_MemGnt) begin
                  if (sel2) pend2_d = 1'b0;
                  else      pend1_d = 1'b0;
                  if (!cur_we) begin
                     tag_d   = sel2 ? 2'b10 : (shared_q ? 2'b11 : 2'b01);
                     state_d = S_RDWAIT;
                  end else if (sel2 || !pend2_q) begin
                     // the granted store was the last pending access
                     state_d = S_DONE;
                  end
               end
            end else begin
               state_d = S_DONE;
            end
         end

         S_RDWAIT: begin
            if (tag_q[0]) rd1_d = i_MemRData;
            if (tag_q[1]) rd2_d = i_MemRData;
            state_d = (pend1_q | pend2_q) ? S_BUSY : S_DONE;
         end

         default: begin
            // DONE: pipeline still shows the finished pair, so inputs are ignored
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q  <= S_IDLE;
         pend1_q  <= 1'b0;
         pend2_q  <= 1'b0;
         we1_q    <= 1'b0;
         we2_q    <= 1'b0;
         shared_q <= 1'b0;
         tag_q    <= 2'b00;
         addr1_q  <= '0;
         addr2_q  <= '0;
         wdata1_q <= '0;
         wdata2_q <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
      end else begin
         state_q  <= state_d;
         pend1_q  <= pend1_d;
         pend2_q  <= pend2_d;
         we1_q    <= we1_d;
         we2_q    <= we2_d;
         shared_q <= shared_d;
         tag_q    <= tag_d;
         addr1_q  <= addr1_d;
         addr2_q  <= addr2_d;
         wdata1_q <= wdata1_d;
         wdata2_q <= wdata2_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
      end
   end

   // Outputs are gated by reset so a mid-access reset drops them at once,
   // even while the pipeline still presents a request in IDLE.
   assign o_Stall    = ~rst_n & (((state_q == S_IDLE) & (req1 | req2)) |
                                 (state_q == S_BUSY) | (state_q == S_RDWAIT));
   assign o_Done     = ~rst_n & (state_q == S_DONE);
   assign o_MemReq   = ~rst_n & (state_q == S_BUSY) & (pend1_q | pend2_q);
   assign o_MemWE    = o_MemReq & cur_we;
   assign o_MemAddr  = o_MemReq ? cur_addr  : '0;
   assign o_MemWData = o_MemReq ? cur_wdata : '0;
   assign o_RD1      = rd1_q;
   assign o_RD2      = rd2_q;

endmodule

// File: tb/tb_dmem_port_sched.sv
// Directed bench for dmem_port_sched with a small behavioural memory.
module tb_dmem_port_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rd1 = 0, wr1 = 0, rd2 = 0, wr2 = 0;
   logic [31:0] a1 = 0, d1 = 0, a2 = 0, d2 = 0;
   logic        stall, done, mreq, mwe, gnt = 0;
   logic [31:0] rdo1, rdo2, maddr, mwdata, mrdata;

   int n_run = 0, n_fail = 0;
   int gnt_wait = 0;
   logic [31:0] hold_addr = 0;

   // access log written only by the memory model
   int          nacc = 0;
   logic [31:0] log_addr [0:63];
   logic [31:0] log_data [0:63];
   logic        log_we   [0:63];
   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   dmem_port_sched #(.D_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_MemRead1(rd1), .i_MemWrite1(wr1), .i_Addr1(a1), .i_WData1(d1),
      .i_MemRead2(rd2), .i_MemWrite2(wr2), .i_Addr2(a2), .i_WData2(d2),
      .o_Stall(stall), .o_Done(done), .o_RD1(rdo1), .o_RD2(rdo2),
      .o_MemReq(mreq), .o_MemWE(mwe), .o_MemAddr(maddr), .o_MemWData(mwdata),
      .i_MemGnt(gnt), .i_MemRData(mrdata)
   );

   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[8]  <= 32'h11;   // 0x20
         mem[9]  <= 32'h22;   // 0x24
         mrdata  <= 32'h0;
      end else if (mreq && gnt) begin
         log_addr[nacc[5:0]] <= maddr;
         log_data[nacc[5:0]] <= mwdata;
         log_we[nacc[5:0]]   <= mwe;
         nacc <= nacc + 1;
         if (mwe) mem[maddr[7:2]] <= mwdata;
         else     mrdata <= mem[maddr[7:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one pair, serve grants after gnt_wait cycles, return the cycle of
   // o_Done (cycle 1 = capture cycle) and the number of stalled cycles.
   task automatic run_pair(input logic r1, w1, input logic [31:0] ad1, da1,
                           input logic r2, w2, input logic [31:0] ad2, da2,
                           output int done_cyc, output int stall_cyc);
      int waited = 0;
      done_cyc = 0; stall_cyc = 0;
      rd1 = r1; wr1 = w1; a1 = ad1; d1 = da1;
      rd2 = r2; wr2 = w2; a2 = ad2; d2 = da2;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (mreq) begin
            if (waited < gnt_wait) begin
               gnt = 0;
               waited++;
               chk("hold_addr", maddr, hold_addr);
               chk("hold_stall", {31'b0, stall}, 32'd1);
            end else begin
               gnt = 1;
               waited = 0;
            end
         end else gnt = 0;
         if (stall) stall_cyc++;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      if (done_cyc == 0) chk("timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
      gnt = 0;
   endtask

   int dc, sc, base;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_req", {31'b0, mreq}, 0);
      chk("rst_rd1", rdo1, 0);
      chk("rst_addr", maddr, 0);
      rst_n = 0;
      @(posedge clk); #1;

      // single lane-1 store
      base = nacc;
      run_pair(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, dc, sc);
      chk("st_done_cyc", dc, 3);
      chk("st_stall", sc, 2);
      chk("st_nacc", nacc - base, 1);
      chk("st_addr", log_addr[base], 32'h10);
      chk("st_we", {31'b0, log_we[base]}, 1);
      chk("st_data", log_data[base], 32'hDEADBEEF);

      // two loads, lane 1 first
      base = nacc;
      run_pair(1, 0, 32'h20, 0, 1, 0, 32'h24, 0, dc, sc);
      chk("ld_done_cyc", dc, 6);
      chk("ld_stall", sc, 5);
      chk("ld_nacc", nacc - base, 2);
      chk("ld_first", log_addr[base], 32'h20);
      chk("ld_rd1", rdo1, 32'h11);
      chk("ld_rd2", rdo2, 32'h22);

      // store -> load forward
      base = nacc;
      run_pair(0, 1, 32'h30, 32'h5A5A, 1, 0, 32'h30, 0, dc, sc);
      chk("fw_nacc", nacc - base, 1);
      chk("fw_we", {31'b0, log_we[base]}, 1);
      chk("fw_rd2", rdo2, 32'h5A5A);
      chk("fw_rd1_kept", rdo1, 32'h11);
      chk("fw_done_cyc", dc, 3);

      // two stores to one address: only the younger is issued
      base = nacc;
      run_pair(0, 1, 32'h40, 32'h1, 0, 1, 32'h40, 32'h2, dc, sc);
      chk("ww_nacc", nacc - base, 1);
      chk("ww_addr", log_addr[base], 32'h40);
      chk("ww_data", log_data[base], 32'h2);
      chk("ww_mem", mem[16], 32'h2);

      // shared load: one access fills both results
      base = nacc;
      run_pair(1, 0, 32'h10, 0, 1, 0, 32'h10, 0, dc, sc);
      chk("rr_nacc", nacc - base, 1);
      chk("rr_rd1", rdo1, 32'hDEADBEEF);
      chk("rr_rd2", rdo2, 32'hDEADBEEF);
      chk("rr_done_cyc", dc, 4);

      // grant withheld for 4 cycles on a lane-2 load
      base = nacc;
      gnt_wait = 4; hold_addr = 32'h24;
      run_pair(0, 0, 0, 0, 1, 0, 32'h24, 0, dc, sc);
      gnt_wait = 0;
      chk("gw_done_cyc", dc, 8);
      chk("gw_stall", sc, 7);
      chk("gw_nacc", nacc - base, 1);
      chk("gw_rd2", rdo2, 32'h22);
      chk("gw_rd1_kept", rdo1, 32'hDEADBEEF);

      // reset while in RDWAIT
      rd1 = 1; a1 = 32'h20; rd2 = 1; a2 = 32'h24; gnt = 1;
      @(posedge clk); #1;   // BUSY
      @(posedge clk); #1;   // RDWAIT
      gnt = 0;
      chk("rw_stall_pre", {31'b0, stall}, 1);
      rst_n = 1;
      #1;
      chk("rw_req", {31'b0, mreq}, 0);
      chk("rw_stall", {31'b0, stall}, 0);
      chk("rw_done", {31'b0, done}, 0);
      chk("rw_rd1", rdo1, 0);
      chk("rw_rd2", rdo2, 0);
      rd1 = 0; rd2 = 0;
      @(posedge clk); #1;
      rst_n = 0;
      @(posedge clk); #1;
      chk("rw_idle_stall", {31'b0, stall}, 0);
      chk("rw_idle_req", {31'b0, mreq}, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
